// File: rtl/shot_pkg.sv
// Shared types and screen constants for the shot object and its helpers.
package shot_pkg;

  localparam int unsigned COORD_W       = 11;
  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } shot_state_t;

endpackage

// File: rtl/shot_rect_check.sv
// Registered rectangle qualifier and sprite offsets for a 16x16 object.
module shot_rect_check
  import shot_pkg::*;
#(
  parameter int unsigned OBJECT_WIDTH_X  = 16,
  parameter int unsigned OBJECT_HEIGHT_Y = 16
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [COORD_W-1:0]   pixelX,
  input  logic [COORD_W-1:0]   pixelY,
  input  logic [COORD_W-1:0]   topX,
  input  logic [COORD_W-1:0]   topY,
  input  logic                 enable,
  output logic                 InsideRectangle,
  output logic [COORD_W-1:0]   offsetX,
  output logic [COORD_W-1:0]   offsetY
);

  localparam int unsigned EXT_W = COORD_W + 1;

  logic [EXT_W-1:0] px, py, tx, ty, tx_end, ty_end;
  logic             inside_c;

  // One extra bit so the far edge of the box never wraps.
  always_comb begin
    px       = {1'b0, pixelX};
    py       = {1'b0, pixelY};
    tx       = {1'b0, topX};
    ty       = {1'b0, topY};
    tx_end   = tx + EXT_W'(OBJECT_WIDTH_X);
    ty_end   = ty + EXT_W'(OBJECT_HEIGHT_Y);
    inside_c = enable && (px >= tx) && (px < tx_end) && (py >= ty) && (py < ty_end);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
    end else begin
      InsideRectangle <= inside_c;
      offsetX         <= inside_c ? (pixelX - topX) : '0;
      offsetY         <= inside_c ? (pixelY - topY) : '0;
    end
  end

endmodule

// File: rtl/shot_mover.sv
// Single player shot: launch on fire, climb each frame, retire on exit or hit, then cool down.
module shot_mover
  import shot_pkg::*;
#(
  parameter int unsigned OBJECT_WIDTH_X  = 16,
  parameter int unsigned OBJECT_HEIGHT_Y = 16,
  parameter int unsigned SCREEN_W        = SCREEN_WIDTH,
  parameter int unsigned SPEED_Y         = 4,
  parameter int unsigned COOLDOWN_FRAMES = 10
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [COORD_W-1:0]   pixelX,
  input  logic [COORD_W-1:0]   pixelY,
  input  logic                 startOfFrame,
  input  logic                 fire,
  input  logic [COORD_W-1:0]   launchX,
  input  logic [COORD_W-1:0]   launchY,
  input  logic                 collision,
  output logic                 InsideRectangle,
  output logic [COORD_W-1:0]   offsetX,
  output logic [COORD_W-1:0]   offsetY,
  output logic                 shotActive,
  output logic [COORD_W-1:0]   topX,
  output logic [COORD_W-1:0]   topY
);

  localparam int unsigned CNT_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam coord_t      MAX_X = COORD_W'(SCREEN_W - OBJECT_WIDTH_X);
  localparam coord_t      STEP  = COORD_W'(SPEED_Y);

  shot_state_t      state, state_nxt;
  coord_t           top_x_nxt, top_y_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // State and position registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      topX  <= '0;
      topY  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      topX  <= top_x_nxt;
      topY  <= top_y_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: collision outranks the frame move; leaving the top retires the shot.
  always_comb begin
    state_nxt = state;
    top_x_nxt = topX;
    top_y_nxt = topY;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (fire) begin
          state_nxt = FLYING;
          top_x_nxt = (launchX > MAX_X) ? MAX_X : launchX;
          top_y_nxt = launchY;
        end
      end
      FLYING: begin
        if (collision) begin
          state_nxt = COOLDOWN;
          cnt_nxt   = CNT_W'(COOLDOWN_FRAMES);
        end else if (startOfFrame) begin
          if (topY < STEP) begin
            state_nxt = COOLDOWN;
            cnt_nxt   = CNT_W'(COOLDOWN_FRAMES);
          end else begin
            top_y_nxt = topY - STEP;
          end
        end
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
          else           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    shotActive = 1'b0;
    if (state == FLYING) shotActive = 1'b1;
  end

  shot_rect_check #(
    .OBJECT_WIDTH_X  (OBJECT_WIDTH_X),
    .OBJECT_HEIGHT_Y (OBJECT_HEIGHT_Y)
  ) u_rect (
    .clk             (clk),
    .resetN          (resetN),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .topX            (topX),
    .topY            (topY),
    .enable          (shotActive),
    .InsideRectangle (InsideRectangle),
    .offsetX         (offsetX),
    .offsetY         (offsetY)
  );

endmodule

// File: tb/tb_shot_mover.sv
// Directed bench for shot_mover: launch, clamp, rectangle, exit, cooldown, collision, reset.
module tb_shot_mover;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY, launchX, launchY;
  logic        startOfFrame, fire, collision;
  logic        InsideRectangle, shotActive;
  logic [10:0] offsetX, offsetY, topX, topY;

  int total = 0;
  int bad   = 0;

  shot_mover dut (
    .clk             (clk),
    .resetN          (resetN),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .startOfFrame    (startOfFrame),
    .fire            (fire),
    .launchX         (launchX),
    .launchY         (launchY),
    .collision       (collision),
    .InsideRectangle (InsideRectangle),
    .offsetX         (offsetX),
    .offsetY         (offsetY),
    .shotActive      (shotActive),
    .topX            (topX),
    .topY            (topY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    fire         = 1'b0;
    collision    = 1'b0;
    pixelX       = '0;
    pixelY       = '0;
    launchX      = '0;
    launchY      = '0;
    #3;
    resetN = 1'b1;
  endtask

  task automatic launch(input int x, input int y);
    launchX = 11'(x);
    launchY = 11'(y);
    fire    = 1'b1;
    tick();
    fire    = 1'b0;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic pix(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
  endtask

  int launches;
  logic prev_active;

  initial begin
    do_reset();
    #1;
    chk("rst_active", 32'(shotActive), 0);
    chk("rst_topx", 32'(topX), 0);
    chk("rst_topy", 32'(topY), 0);
    chk("rst_inside", 32'(InsideRectangle), 0);
    chk("rst_offx", 32'(offsetX), 0);
    chk("rst_offy", 32'(offsetY), 0);

    // Collision outside FLYING does nothing.
    tick();
    collision = 1'b1;
    tick();
    collision = 1'b0;
    chk("idle_coll_active", 32'(shotActive), 0);

    // Basic launch and one frame move.
    launch(300, 400);
    chk("l1_active", 32'(shotActive), 1);
    chk("l1_topx", 32'(topX), 300);
    chk("l1_topy", 32'(topY), 400);
    frame();
    chk("l1_move_topy", 32'(topY), 396);
    chk("l1_move_topx", 32'(topX), 300);

    // Clamp and rectangle edges.
    do_reset();
    tick();
    launch(635, 400);
    chk("clamp_topx", 32'(topX), 624);
    pix(624, 400);
    chk("tl_inside", 32'(InsideRectangle), 1);
    chk("tl_offx", 32'(offsetX), 0);
    chk("tl_offy", 32'(offsetY), 0);
    pix(639, 415);
    chk("br_inside", 32'(InsideRectangle), 1);
    chk("br_offx", 32'(offsetX), 15);
    chk("br_offy", 32'(offsetY), 15);
    pix(640, 400);
    chk("rx_inside", 32'(InsideRectangle), 0);
    chk("rx_offx", 32'(offsetX), 0);
    chk("rx_offy", 32'(offsetY), 0);
    pix(623, 400);
    chk("lx_inside", 32'(InsideRectangle), 0);
    pix(630, 416);
    chk("by_inside", 32'(InsideRectangle), 0);
    pix(630, 399);
    chk("ty_inside", 32'(InsideRectangle), 0);

    // Exit off the top, then cooldown of 11 frame pulses.
    do_reset();
    tick();
    launch(100, 6);
    frame();
    chk("exit_topy2", 32'(topY), 2);
    chk("exit_active1", 32'(shotActive), 1);
    frame();
    chk("exit_active0", 32'(shotActive), 0);
    chk("exit_hold_topy", 32'(topY), 2);
    launchX = 11'd200;
    launchY = 11'd50;
    fire    = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      frame();
      chk($sformatf("cd_active_%0d", i), 32'(shotActive), 0);
    end
    chk("cd_hold_topx", 32'(topX), 100);
    startOfFrame = 1'b1;
    fire         = 1'b0;
    tick();
    startOfFrame = 1'b0;
    chk("cd_idle_active", 32'(shotActive), 0);
    launch(200, 50);
    chk("cd_relaunch_active", 32'(shotActive), 1);
    chk("cd_relaunch_topx", 32'(topX), 200);
    chk("cd_relaunch_topy", 32'(topY), 50);

    // Collision beats frame move.
    do_reset();
    tick();
    launch(50, 200);
    pix(50, 200);
    chk("pre_coll_inside", 32'(InsideRectangle), 1);
    collision    = 1'b1;
    startOfFrame = 1'b1;
    tick();
    collision    = 1'b0;
    startOfFrame = 1'b0;
    chk("coll_active", 32'(shotActive), 0);
    chk("coll_topy", 32'(topY), 200);
    tick();
    chk("coll_inside", 32'(InsideRectangle), 0);

    // Fire held 100 clks -> exactly one launch, no relaunch.
    do_reset();
    tick();
    launches    = 0;
    prev_active = shotActive;
    launchX     = 11'd300;
    launchY     = 11'd400;
    fire        = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (shotActive && !prev_active) launches++;
      prev_active = shotActive;
      launchX = 11'd10;
      launchY = 11'd20;
    end
    fire = 1'b0;
    chk("hold_launches", launches, 1);
    chk("hold_topx", 32'(topX), 300);
    chk("hold_topy", 32'(topY), 400);

    // Asynchronous reset mid-flight.
    do_reset();
    tick();
    launch(300, 120);
    pix(305, 125);
    chk("mid_inside", 32'(InsideRectangle), 1);
    chk("mid_offx", 32'(offsetX), 5);
    #2;
    resetN = 1'b0;
    #1;
    chk("ar_active", 32'(shotActive), 0);
    chk("ar_topx", 32'(topX), 0);
    chk("ar_topy", 32'(topY), 0);
    chk("ar_inside", 32'(InsideRectangle), 0);
    chk("ar_offx", 32'(offsetX), 0);
    chk("ar_offy", 32'(offsetY), 0);
    resetN = 1'b1;
    tick();
    launch(40, 60);
    chk("post_rst_active", 32'(shotActive), 1);
    chk("post_rst_topx", 32'(topX), 40);
    chk("post_rst_topy", 32'(topY), 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shot_mover.md
Name: shot_mover

Overview:
- Owns the position and lifecycle of a single player shot.
- On a fire request it launches the shot from the player position and moves it upward each frame.
- The shot is retired when it leaves the top of the screen or when a collision is reported.
- Per pixel it produces the registered rectangle qualifier and the 16x16 offsets that the downstream shot bitmap consumes (InsideRectangle, offsetX, offsetY).

Parameters:
- OBJECT_WIDTH_X, 16, shot sprite width in pixels.
- OBJECT_HEIGHT_Y, 16, shot sprite height in pixels.
- SCREEN_WIDTH, 640, visible width; launch X is clamped to SCREEN_WIDTH-OBJECT_WIDTH_X.
- SPEED_Y, 4, pixels moved upward per startOfFrame.
- COOLDOWN_FRAMES, 10, frames after retirement before a new shot is accepted.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- pixelX  in  11  current VGA pixel column.
- pixelY  in  11  current VGA pixel row.
- startOfFrame  in  1  one-clk pulse per frame.
- fire  in  1  launch request, level or pulse; sampled every clk.
- launchX  in  11  player top-left X at launch.
- launchY  in  11  player top-left Y at launch.
- collision  in  1  shot hit something; one-clk pulse.
- InsideRectangle  out  1  registered: current pixel lies inside the active shot.
- offsetX  out  11  registered: pixelX - topX when inside, else 0.
- offsetY  out  11  registered: pixelY - topY when inside, else 0.
- shotActive  out  1  high while in FLYING.
- topX  out  11  current shot top-left X.
- topY  out  11  current shot top-left Y.

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE, topX=0, topY=0, cooldown counter=0.
  - InsideRectangle=0, offsetX=0, offsetY=0, shotActive=0.
- States: IDLE, FLYING, COOLDOWN.
- IDLE:
  - On fire=1: next clk go to FLYING.
  - topX <= min(launchX, SCREEN_WIDTH-OBJECT_WIDTH_X).
  - topY <= launchY.
- FLYING, evaluated in priority order each clk:
  1. collision=1: go to COOLDOWN, counter <= COOLDOWN_FRAMES; no move this clk even if startOfFrame=1.
  2. startOfFrame=1 and topY < SPEED_Y: shot leaves the screen; go to COOLDOWN, counter <= COOLDOWN_FRAMES.
  3. startOfFrame=1 otherwise: topY <= topY - SPEED_Y; topX unchanged.
- FLYING, fire: ignored; no relaunch while FLYING.
- COOLDOWN:
  - On each startOfFrame: if counter>0, counter <= counter-1; else go to IDLE.
  - Total wait is COOLDOWN_FRAMES+1 frame pulses.
  - fire and collision are ignored.
  - topX/topY hold their last values.
- IDLE with fire and startOfFrame in the same clk: launch only; the first move happens on the next startOfFrame.
- shotActive = (state==FLYING), combinational from the state register.
- Rectangle stage, registered with 1 clk latency from pixelX/pixelY:
  - inside = shotActive and topX<=pixelX<topX+OBJECT_WIDTH_X and topY<=pixelY<topY+OBJECT_HEIGHT_Y.
  - Comparisons are done at 12 bits so topX+W cannot wrap.
  - InsideRectangle <= inside.
  - offsetX <= inside ? pixelX-topX : 0; offsetY <= inside ? pixelY-topY : 0.
  - Offsets are always in 0..15 when inside, so they index the 16x16 bitmap directly.
- The rectangle stage uses the topX/topY register values of the current clk. A position update on a startOfFrame clk affects the next pixel evaluated.
- collision asserted outside FLYING: no effect.
- resetN asserted mid-flight: immediate return to reset values; the shot disappears on the next pixel.

Decomposition:
- Shared package shot_pkg:
  - typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} shot_state_t.
  - coordinate typedef logic [10:0] coord_t.
  - screen constants 640/480.
- One sub-module, shot_rect_check: the registered rectangle/offset stage.
  - Inputs: clk, resetN, pixelX, pixelY, topX, topY, enable.
  - Outputs: InsideRectangle, offsetX, offsetY.
  - Reusable by other 16x16 objects.

Test Plan:
- Reset then fire=1 one clk with launchX=300, launchY=400 -> shotActive=1, topX=300, topY=400. Next startOfFrame -> topY=396.
- launchX=635 fire -> topX=624 (clamped). Pixel (624,400) -> next clk InsideRectangle=1, offset (0,0). Pixel (639,415) -> offset (15,15). Pixel (640,400) -> InsideRectangle=0, offset (0,0).
- Launch topY=6, then pulse startOfFrame twice:
  - first -> topY=2;
  - second -> COOLDOWN, shotActive=0;
  - fire during the next 10 frames -> ignored;
  - after the 11th frame pulse -> IDLE; fire accepted.
- collision and startOfFrame in the same clk while FLYING at topY=200 -> COOLDOWN, topY stays 200, InsideRectangle=0 thereafter.
- fire held high for 100 clks from IDLE -> exactly one launch. Second fire while FLYING does not change topX/topY.
- resetN low while FLYING at topY=120 -> outputs 0 and state IDLE immediately. Release, then fire -> normal launch.
